// File: rtl/multi_dataflow_job_sequencer.sv
// Job sequencer for a reconfigurable dataflow kernel: queues jobs, reconfigures on ID change, tracks outputs.
// Optional busy-cycle performance counter enabled by defining MDF_JOB_SEQ_PERF_EN.
module multi_dataflow_job_sequencer #(
   parameter int unsigned QUEUE_DEPTH   = 4,
   parameter int unsigned RECONF_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        job_valid_i,
   output logic        job_ready_o,
   input  logic [31:0] job_id_i,
   input  logic [31:0] job_len_i,
   output logic        kernel_start_o,
   output logic [31:0] kernel_id_o,
   input  logic        kernel_done_i,
   output logic        job_done_o,
   output logic [31:0] job_done_id_o,
   output logic        busy_o,
   output logic [31:0] perf_busy_cycles_o
);

   localparam int unsigned AW        = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(QUEUE_DEPTH);
   localparam logic [31:0] WAIT_LAST = 32'(RECONF_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_RECONF, S_START, S_RUN, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [31:0]   id_mem_q  [QUEUE_DEPTH];
   logic [31:0]   len_mem_q [QUEUE_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   kernel_id_q, kernel_id_d;
   logic [31:0]   cur_id_q, cur_id_d;
   logic [31:0]   cur_len_q, cur_len_d;
   logic [31:0]   out_cnt_q, out_cnt_d;
   logic [31:0]   wait_q, wait_d;
   logic          push, pop, q_empty, q_full;
   logic [31:0]   head_id, head_len;

   assign q_empty = (count_q == '0);
   assign q_full  = (count_q == FULL_CNT);
   assign head_id  = id_mem_q[rd_ptr_q];
   assign head_len = len_mem_q[rd_ptr_q];
   assign push     = job_valid_i & ~q_full & ~clear_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         id_mem_q[wr_ptr_q]  <= job_id_i;
         len_mem_q[wr_ptr_q] <= job_len_i;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // kernel_id is loaded at pop time so it already shows the new ID in the first RECONF cycle.
   always_comb begin
      state_d     = state_q;
      kernel_id_d = kernel_id_q;
      cur_id_d    = cur_id_q;
      cur_len_d   = cur_len_q;
      out_cnt_d   = out_cnt_q;
      wait_d      = wait_q;
      pop         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!q_empty) begin
               pop         = 1'b1;
               cur_id_d    = head_id;
               cur_len_d   = head_len;
               kernel_id_d = head_id;
               wait_d      = '0;
               if (head_id != kernel_id_q) state_d = S_RECONF;
               else if (head_len == '0)    state_d = S_DONE;
               else                        state_d = S_START;
            end
         end
         S_RECONF: begin
            if (wait_q == WAIT_LAST) state_d = (cur_len_q == '0) ? S_DONE : S_START;
            else                     wait_d  = wait_q + 32'd1;
         end
         S_START: begin
            out_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (kernel_done_i) begin
               out_cnt_d = out_cnt_q + 32'd1;
               if (out_cnt_q + 32'd1 == cur_len_q) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (clear_i) begin
         state_d     = S_IDLE;
         pop         = 1'b0;
         kernel_id_d = kernel_id_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         kernel_id_q <= '0;
         cur_id_q    <= '0;
         cur_len_q   <= '0;
         out_cnt_q   <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         kernel_id_q <= kernel_id_d;
         cur_id_q    <= cur_id_d;
         cur_len_q   <= cur_len_d;
         out_cnt_q   <= out_cnt_d;
         wait_q      <= wait_d;
      end
   end

   assign job_ready_o    = ~q_full;
   assign kernel_id_o    = kernel_id_q;
   assign busy_o         = (state_q != S_IDLE) | ~q_empty;
   assign kernel_start_o = (state_q == S_START) & ~clear_i;
   assign job_done_o     = (state_q == S_DONE) & ~clear_i;
   assign job_done_id_o  = job_done_o ? cur_id_q : '0;

`ifdef MDF_JOB_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (clear_i)                      perf_d = '0;
      else if (busy_o && perf_q != '1) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= '0;
      else         perf_q <= perf_d;
   end

   assign perf_busy_cycles_o = perf_q;
`else
   assign perf_busy_cycles_o = '0;
`endif

endmodule

// File: doc/multi_dataflow_job_sequencer.md
MULTI_DATAFLOW_JOB_SEQUENCER -- requirements
Module: multi_dataflow_job_sequencer

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, job FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RECONF_CYCLES, default 2, wait cycles after a kernel ID change before START (>=1).
REQ-003 SHALL have clk_i  input  1  clock; all state on rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have clear_i  input  1  synchronous flush of queue and FSM.
REQ-006 SHALL have job_valid_i  input  1, job_ready_o  output  1  job push handshake.
REQ-007 SHALL have job_id_i  input  32  kernel ID of pushed job.
REQ-008 SHALL have job_len_i  input  32  number of kernel outputs expected for the job.
REQ-009 SHALL have kernel_start_o  output  1  single-cycle start pulse to the kernel adapter.
REQ-010 SHALL have kernel_id_o  output  32  ID driven to the reconfigurable datapath.
REQ-011 SHALL have kernel_done_i  input  1  one pulse per accepted kernel output.
REQ-012 SHALL have job_done_o  output  1, job_done_id_o  output  32  completion pulse and ID of the finished job.
REQ-013 SHALL have busy_o  output  1  high whenever FSM is not IDLE or queue is non-empty.
REQ-014 SHALL have perf_busy_cycles_o  output  32  busy cycle counter (see Configuration).

Function
REQ-015 Job FIFO SHALL push on job_valid_i & job_ready_o; job_ready_o = queue not full, independent of pop (no full-bypass).
REQ-016 FSM states SHALL be IDLE, RECONF, START, RUN, DONE.
REQ-017 IDLE: queue non-empty -> pop head into current-job registers; next state RECONF if head ID != kernel_id_o, else START.
REQ-018 RECONF: kernel_id_o updates to new ID on entry; wait counter runs RECONF_CYCLES cycles, then START.
REQ-019 START: kernel_start_o = 1 for exactly this cycle; output counter cleared; next RUN; kernel_id_o stable from START through DONE.
REQ-020 RUN: each kernel_done_i pulse increments a 32-bit output counter; when counter+1 == job_len, next DONE.
REQ-021 DONE: job_done_o = 1 and job_done_id_o = job ID for one cycle; next IDLE (dequeue of next job may occur on the following cycle).
REQ-022 job_len = 0 SHALL skip START/RUN: after RECONF (if any) go directly to DONE; no start pulse issued.
REQ-023 kernel_done_i outside RUN SHALL be ignored.
REQ-024 Job latency from push into empty idle queue with same ID SHALL be: pop cycle+1 -> START, i.e. kernel_start_o 2 cycles after push.
REQ-025 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-026 clear_i SHALL empty the queue and force IDLE next cycle, suppressing any pending start/done pulse; kernel_id_o retained; has priority over push.

Reset
REQ-027 On rst_ni low: FSM IDLE, queue empty, counters 0, kernel_start_o 0, job_done_o 0, job_done_id_o 0, kernel_id_o 0, busy_o 0, perf_busy_cycles_o 0.
REQ-028 Reset mid-job SHALL abort immediately with no done pulse; job_ready_o = 1 after release.

Configuration
REQ-029 Macro MDF_JOB_SEQ_PERF_EN defined: perf_busy_cycles_o counts cycles with busy_o = 1, saturating at 0xFFFFFFFF, cleared by reset and clear_i.
REQ-030 Macro MDF_JOB_SEQ_PERF_EN undefined: counter not implemented; perf_busy_cycles_o tied to 0.

Verification
REQ-031 Push (ID=0,len=3), three done pulses -> one start pulse, job_done_o with job_done_id_o=0 on cycle after 3rd done.
REQ-032 Push (ID=1,len=2) after ID=0 job -> kernel_id_o=1 then 2 RECONF cycles, then start pulse; done after 2 outputs.
REQ-033 Push 5 jobs with QUEUE_DEPTH=4 while stalled -> job_ready_o low after 4th push, 5th accepted after first pop.
REQ-034 Push (ID=0,len=0) -> no kernel_start_o, job_done_o pulse within 3 cycles.
REQ-035 clear_i asserted in RUN with 2 queued jobs -> IDLE next cycle, busy_o=0, no job_done_o; stray kernel_done_i ignored.
REQ-036 With MDF_JOB_SEQ_PERF_EN, one len=3 same-ID job -> perf_busy_cycles_o equals busy_o-high cycle count; without macro stays 0.
